// File: rtl/write_through_register_file.sv
// Multi-port register file with write-through reads and prioritised write ports.
// Define GRF_WRITE_LOG_EN to print a commit log in simulation.
`timescale 1ns/1ps

module write_through_register_file #(
  parameter int unsigned          DATA_SIZE     = 32,
  parameter int unsigned          ADDR_SIZE     = 5,
  parameter int unsigned          READ_PORTS    = 3,
  parameter int unsigned          WRITE_PORTS   = 2,
  parameter logic [DATA_SIZE-1:0] INITIAL_VALUE = '0,
  parameter int unsigned          ZERO_REG      = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [READ_PORTS*ADDR_SIZE-1:0]   read_addr,
  output logic [READ_PORTS*DATA_SIZE-1:0]   read_data,
  input  logic [WRITE_PORTS-1:0]            write_enable,
  input  logic [WRITE_PORTS*ADDR_SIZE-1:0]  write_addr,
  input  logic [WRITE_PORTS*DATA_SIZE-1:0]  write_data,
  input  logic [WRITE_PORTS*32-1:0]         write_pc
);

  localparam int DEPTH   = 1 << ADDR_SIZE;
  localparam bit ZERO_EN = (ZERO_REG != 0);

  logic [DATA_SIZE-1:0]   r_mem [DEPTH];
  logic [WRITE_PORTS-1:0] w_writeLive;
  logic [DATA_SIZE-1:0]   w_readVal;

  // A write to entry 0 is dropped entirely when it is hardwired, so it never bypasses.
  always_comb begin
    w_writeLive = '0;
    for (int w = 0; w < int'(WRITE_PORTS); w++) begin
      w_writeLive[w] = write_enable[w] &&
                       !(ZERO_EN && (write_addr[w*ADDR_SIZE +: ADDR_SIZE] == '0));
    end
  end

  // Ascending port order lets the highest-index port's assignment land last on a collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= (ZERO_EN && (i == 0)) ? '0 : INITIAL_VALUE;
      end
    end else begin
      for (int w = 0; w < int'(WRITE_PORTS); w++) begin
        if (w_writeLive[w]) begin
          r_mem[write_addr[w*ADDR_SIZE +: ADDR_SIZE]] <= write_data[w*DATA_SIZE +: DATA_SIZE];
        end
      end
    end
  end

  always_comb begin
    read_data = '0;
    w_readVal = '0;
    for (int r = 0; r < int'(READ_PORTS); r++) begin
      w_readVal = r_mem[read_addr[r*ADDR_SIZE +: ADDR_SIZE]];
      if (!reset) begin
        for (int w = 0; w < int'(WRITE_PORTS); w++) begin
          if (w_writeLive[w] &&
              (write_addr[w*ADDR_SIZE +: ADDR_SIZE] == read_addr[r*ADDR_SIZE +: ADDR_SIZE])) begin
            w_readVal = write_data[w*DATA_SIZE +: DATA_SIZE];
          end
        end
      end
      if (ZERO_EN && (read_addr[r*ADDR_SIZE +: ADDR_SIZE] == '0)) begin
        w_readVal = '0;
      end
      read_data[r*DATA_SIZE +: DATA_SIZE] = w_readVal;
    end
  end

`ifdef GRF_WRITE_LOG_EN
  logic [WRITE_PORTS-1:0] w_logShow;

  // Only the write that actually lands in an entry is logged.
  always_comb begin
    w_logShow = w_writeLive;
    for (int w = 0; w < int'(WRITE_PORTS); w++) begin
      for (int v = w + 1; v < int'(WRITE_PORTS); v++) begin
        if (w_writeLive[v] &&
            (write_addr[v*ADDR_SIZE +: ADDR_SIZE] == write_addr[w*ADDR_SIZE +: ADDR_SIZE])) begin
          w_logShow[w] = 1'b0;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (!reset) begin
      for (int w = 0; w < int'(WRITE_PORTS); w++) begin
        if (w_logShow[w]) begin
          $display("@%08h: $%02d <= %08h", write_pc[w*32 +: 32],
                   write_addr[w*ADDR_SIZE +: ADDR_SIZE], write_data[w*DATA_SIZE +: DATA_SIZE]);
        end
      end
    end
  end
`else
  logic w_unusedPc;
  assign w_unusedPc = ^write_pc;
`endif

endmodule

// File: tb/tb_write_through_register_file.sv
// Scoreboard bench for write_through_register_file: random and directed stimulus
// against an array-based reference model; a separate monitor compares reads.
`timescale 1ns/1ps

module tb_write_through_register_file;

  localparam int D  = 32;
  localparam int A  = 5;
  localparam int RP = 3;
  localparam int WP = 2;

  logic            clk;
  logic            reset;
  logic [RP*A-1:0] read_addr;
  logic [RP*D-1:0] read_data;
  logic [WP-1:0]   write_enable;
  logic [WP*A-1:0] write_addr;
  logic [WP*D-1:0] write_data;
  logic [WP*32-1:0] write_pc;

  write_through_register_file dut (
    .clk          (clk),
    .reset        (reset),
    .read_addr    (read_addr),
    .read_data    (read_data),
    .write_enable (write_enable),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .write_pc     (write_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          port;
    logic [31:0] exp;
    string       tag;
  } exp_t;

  logic [31:0] mdl [32];
  exp_t        sbQ [$];
  event        sampleEv;
  int          checks   = 0;
  int          failures = 0;

  // Reference model: registers are plain array slots, entry 0 is always zero.
  function automatic void modelReset();
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
  endfunction

  function automatic void modelCommit();
    logic [4:0] a;
    if (reset) return;
    for (int w = 0; w < WP; w++) begin
      a = write_addr[w*A +: A];
      if (write_enable[w] && a != 5'd0) mdl[a] = write_data[w*D +: D];
    end
  endfunction

  function automatic logic [31:0] modelRead(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (!reset) begin
      for (int w = WP - 1; w >= 0; w--) begin
        if (write_enable[w] && write_addr[w*A +: A] == a) return write_data[w*D +: D];
      end
    end
    return mdl[a];
  endfunction

  task automatic pushReads(input string tag);
    exp_t e;
    for (int r = 0; r < RP; r++) begin
      e.port = r;
      e.exp  = modelRead(read_addr[r*A +: A]);
      e.tag  = tag;
      sbQ.push_back(e);
    end
    #1 ->sampleEv;
    #1;
  endtask

  task automatic applyStimulus(input logic rst, input logic [1:0] we, input logic [9:0] wa,
                               input logic [63:0] wd, input logic [14:0] ra, input string tag);
    @(posedge clk);
    modelCommit();
    #1;
    reset        = rst;
    write_enable = we;
    write_addr   = wa;
    write_data   = wd;
    read_addr    = ra;
    write_pc     = {$urandom, $urandom};
    if (rst) modelReset();
    pushReads(tag);
  endtask

  task automatic checkOutput();
    exp_t        e;
    logic [31:0] got;
    while (sbQ.size() > 0) begin
      e   = sbQ.pop_front();
      got = read_data[e.port*D +: D];
      checks++;
      if (got !== e.exp) begin
        failures++;
        $display("[TB] FAIL %s port%0d addr=%0d: got %08h expected %08h",
                 e.tag, e.port, read_addr[e.port*A +: A], got, e.exp);
      end
    end
  endtask

  initial begin
    forever begin
      @(sampleEv);
      checkOutput();
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [4:0] randAddr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 3));
    return 5'($urandom_range(0, 31));
  endfunction

  initial begin
    logic [4:0] a0, a1, r0, r1, r2;
    reset        = 1'b0;
    write_enable = '0;
    write_addr   = '0;
    write_data   = '0;
    read_addr    = '0;
    write_pc     = '0;
    modelReset();
    #1 reset = 1'b1;

    applyStimulus(1'b1, 2'b00, 10'd0, 64'd0, {5'd3, 5'd2, 5'd1}, "resetState");
    applyStimulus(1'b0, 2'b00, 10'd0, 64'd0, {5'd31, 5'd0, 5'd9}, "resetRelease");

    for (int a = 1; a < 32; a += 2) begin
      a0 = 5'(a);
      a1 = 5'(a + 1);
      applyStimulus(1'b0, 2'b11, {a1, a0}, {32'hA5A5A5A5, 32'hA5A5A5A5},
                    {randAddr(), randAddr(), randAddr()}, "fill");
    end
    applyStimulus(1'b0, 2'b00, 10'd0, 64'd0, {5'd31, 5'd16, 5'd1}, "filled");

    // Pulse reset between clock edges; contents must clear without an edge.
    reset     = 1'b1;
    read_addr = {5'd31, 5'd17, 5'd1};
    modelReset();
    pushReads("asyncReset");
    #1 reset = 1'b0;
    read_addr = {5'd30, 5'd12, 5'd2};
    pushReads("asyncRelease");

    applyStimulus(1'b0, 2'b01, {5'd0, 5'd5}, {32'h0, 32'h12345678}, {5'd0, 5'd0, 5'd5}, "writeThrough");
    applyStimulus(1'b0, 2'b00, 10'd0, 64'd0, {5'd0, 5'd0, 5'd5}, "writeThroughHold");

    applyStimulus(1'b0, 2'b11, {5'd7, 5'd7}, {32'h22222222, 32'h11111111}, {5'd0, 5'd7, 5'd7}, "collision");
    applyStimulus(1'b0, 2'b00, 10'd0, 64'd0, {5'd7, 5'd7, 5'd0}, "collisionHold");

    applyStimulus(1'b0, 2'b11, {5'd0, 5'd3}, {32'hFFFFFFFF, 32'h0000BEEF}, {5'd0, 5'd3, 5'd0}, "zeroReg");
    applyStimulus(1'b0, 2'b00, 10'd0, 64'd0, {5'd3, 5'd0, 5'd0}, "zeroRegHold");

    applyStimulus(1'b0, 2'b11, {5'd9, 5'd8}, {32'h9, 32'h8}, {5'd0, 5'd0, 5'd0}, "dualWrite");
    applyStimulus(1'b0, 2'b00, 10'd0, 64'd0, {5'd8, 5'd9, 5'd8}, "dualHold");

    applyStimulus(1'b1, 2'b11, {5'd4, 5'd4}, {32'hDEADBEEF, 32'hCAFEF00D}, {5'd4, 5'd4, 5'd4}, "resetWrite");
    applyStimulus(1'b0, 2'b00, 10'd0, 64'd0, {5'd4, 5'd0, 5'd4}, "resetWriteRelease");
    applyStimulus(1'b0, 2'b00, 10'd0, 64'd0, {5'd4, 5'd4, 5'd4}, "resetWriteHold");

    for (int n = 0; n < 400; n++) begin
      a0 = randAddr();
      a1 = randAddr();
      r0 = ($urandom_range(0, 2) == 0) ? a0 : randAddr();
      r1 = ($urandom_range(0, 2) == 0) ? a1 : randAddr();
      r2 = randAddr();
      applyStimulus(1'b0, 2'($urandom_range(0, 3)), {a1, a0}, {$urandom, $urandom},
                    {r2, r1, r0}, "random");
    end

    @(posedge clk);
    #2;
    if (sbQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL scoreboardDrain: got %0d pending expected 0", sbQ.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/write_through_register_file.md
Name: write_through_register_file

Overview:
- Parametrised multi-port register array; each entry is a write-through register.
- Any read port whose address matches an enabled write in the same cycle returns the incoming write data, not the stored value.
- Serves as the general-purpose register file of the pipelined CPU.
- Removes the need for external decode-stage forwarding from the write-back stage.
- Generalises the single write-through register to 2^ADDR_SIZE entries, READ_PORTS read ports and WRITE_PORTS prioritised write ports.

Parameters:
- DATA_SIZE, 32, width of each entry.
- ADDR_SIZE, 5, address width; depth = 2^ADDR_SIZE.
- READ_PORTS, 3, number of independent combinational read ports (1..8).
- WRITE_PORTS, 2, number of write ports (1..4); higher index has higher priority.
- INITIAL_VALUE, 0, value loaded into every entry on reset.
- ZERO_REG, 1, when 1 entry 0 reads as 0 and ignores writes.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- read_addr  input  READ_PORTS*ADDR_SIZE  packed read addresses; port i at bits [i*ADDR_SIZE +: ADDR_SIZE].
- read_data  output  READ_PORTS*DATA_SIZE  packed read data, same packing.
- write_enable  input  WRITE_PORTS  per-port write enable.
- write_addr  input  WRITE_PORTS*ADDR_SIZE  packed write addresses.
- write_data  input  WRITE_PORTS*DATA_SIZE  packed write data.
- write_pc  input  WRITE_PORTS*32  PC of the instruction issuing each write; used only by the optional feature.

Behaviour:
- Reset: asserting reset immediately (no clock needed) sets every entry to INITIAL_VALUE. Entry 0 is excluded when ZERO_REG=1; it always reads 0.
- While reset is high:
  - no writes commit;
  - bypass is suppressed;
  - read_data shows the reset contents (INITIAL_VALUE, or 0 for entry 0 when ZERO_REG=1).
- Reset released mid-cycle: the first commit happens on the first rising edge with reset low.
- Write commit: on each rising edge with reset low, every port w with write_enable[w]=1 writes write_data[w] to entry write_addr[w].
- Same-address collision: when two or more enabled ports target the same address, the highest-index port wins. Lower ports are discarded for that address only.
- Different-address writes in the same cycle all commit.
- Read, combinational, zero latency. For each read port i, in priority order:
  1. ZERO_REG=1 and read_addr[i]=0 -> 0.
  2. Any enabled write port targets read_addr[i] -> write_data of the highest-index such port (write-through).
  3. Otherwise -> stored entry.
- Bypass and commit use the same priority, so a read after the edge equals the bypassed value before it.
- ZERO_REG=1:
  - writes to address 0 are dropped;
  - they neither bypass nor block lower-priority writes to other addresses.
- ZERO_REG=0: entry 0 behaves like every other entry.
- No internal state besides the array; no stall or busy output; reads never wait.
- Address width exactly matches depth; out-of-range addresses cannot occur.
- Read ports are independent. Any number may read the same address with identical results.

Optional Feature:
- Macro GRF_WRITE_LOG_EN.
- Defined (simulation only):
  - On each committing edge, for each enabled port with a non-dropped write, in ascending port index, print: "@<write_pc hex 8 digits>: $<addr decimal 2 digits> <= <data hex 8 digits>".
  - Overridden lower-priority writes to a colliding address are not printed.
  - Dropped address-0 writes are not printed.
- Undefined: no display logic. write_pc is still present but unused. Functional behaviour is identical in both cases.

Test Plan:
- Async reset: with no clock edge, pulse reset with INITIAL_VALUE=0 after filling entries 1..31 with 0xA5A5A5A5 -> all read ports return 0 before the next rising edge.
- Write-through: write_enable=2'b01, write_addr[0]=5, write_data[0]=0x12345678, read_addr[0]=5 -> read_data[0]=0x12345678 in the same cycle; after the edge with write disabled, still 0x12345678.
- Priority collision: both ports write address 7, port0=0x11111111, port1=0x22222222, read_addr[1]=7 -> read_data[1]=0x22222222 in-cycle and after the edge; log (if enabled) shows only port1.
- Zero register: port1 writes 0xFFFFFFFF to addr 0 while port0 writes 0x0000BEEF to addr 3; read ports 0,1,2 = 0,3,0 -> reads 0, 0x0000BEEF, 0; after the edge addr 0 still reads 0 and addr 3 reads 0x0000BEEF.
- Dual distinct writes: port0 addr 8=0x8, port1 addr 9=0x9 in the same cycle -> next cycle, reads of 8 and 9 return 0x8 and 0x9.
- Reset during write: reset high with write_enable=2'b11 to addr 4 -> no commit; read of addr 4 returns INITIAL_VALUE during reset and after release.
